otp_ctrl_part_rd_sched: RTL and testbench

- Shares the single OTP macro read port among NumPart partition buffers.
- Each partition requests a full readout of its byte range (offset, size).
- Round-robin arbiter picks one partition; FSM issues one word read at a time with req/gnt, waits for the response, and routes data back to the winner. Completion is signalled with an ack/err pulse.
- Sits between the partition buffers (init/integrity readout) and the OTP macro adapter.

---
 rtl/otp_ctrl_part_rd_sched.sv | 211 +++++++++++++++++++++
 tb/tb_otp_ctrl_part_rd_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_ctrl_part_rd_sched.sv
// Round-robin scheduler that shares the single OTP macro read port among partition readouts.
// Optional response watchdog enabled by defining OTP_CTRL_RD_SCHED_TIMEOUT_EN.
module otp_ctrl_part_rd_sched #(
  parameter int NumPart          = 8,
  parameter int OtpByteAddrWidth = 11,
  parameter int OtpWordBytes     = 8,
  parameter int TimeoutCycles    = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPart-1:0]                  part_req_i,
  input  logic [NumPart*OtpByteAddrWidth-1:0] part_offset_i,
  input  logic [NumPart*OtpByteAddrWidth-1:0] part_size_i,
  output logic [NumPart-1:0]                  part_ack_o,
  output logic                                part_err_o,
  output logic [NumPart-1:0]                  part_rvalid_o,
  output logic [OtpWordBytes*8-1:0]           part_rdata_o,
  output logic [OtpByteAddrWidth-1:0]         part_rword_o,
  output logic                                otp_req_o,
  output logic [OtpByteAddrWidth-1:0]         otp_addr_o,
  input  logic                                otp_gnt_i,
  input  logic                                otp_rvalid_i,
  input  logic [OtpWordBytes*8-1:0]           otp_rdata_i,
  input  logic                                otp_err_i,
  output logic                                busy_o
);

  localparam int AW   = OtpByteAddrWidth;
  localparam int DW   = OtpWordBytes * 8;
  localparam int IdxW = (NumPart > 1) ? $clog2(NumPart) : 1;

  localparam logic [AW-1:0]      WordStep  = AW'(OtpWordBytes);
  localparam logic [AW-1:0]      WordMask  = AW'(OtpWordBytes - 1);
  localparam logic [AW:0]        AddrSpace = {1'b1, {AW{1'b0}}};
  localparam logic [NumPart-1:0] OneHot0   = NumPart'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCheck = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IdxW-1:0]    rrPtr_q, rrPtr_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      remain_q, remain_d;
  logic [AW-1:0]      wordIdx_q, wordIdx_d;
  logic               err_q, err_d;
  logic [NumPart-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [AW-1:0]      rword_q, rword_d;

  logic [AW-1:0] offArr  [NumPart];
  logic [AW-1:0] sizeArr [NumPart];

  for (genvar k = 0; k < NumPart; k++) begin : gen_unpack
    assign offArr[k]  = part_offset_i[k*AW +: AW];
    assign sizeArr[k] = part_size_i[k*AW +: AW];
  end

  // Rotating priority: the first requester at or after rrPtr_q wins.
  logic            pickValid;
  logic [IdxW-1:0] pickIdx;

  always_comb begin
    int cand;
    cand      = 0;
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int i = NumPart - 1; i >= 0; i--) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= NumPart) cand = cand - NumPart;
      if (part_req_i[cand[IdxW-1:0]]) begin
        pickValid = 1'b1;
        pickIdx   = cand[IdxW-1:0];
      end
    end
  end

  // End address carries one extra bit so a range ending exactly at the top stays legal.
  logic [AW:0] endAddr;
  logic        cfgBad;

  assign endAddr = {1'b0, addr_q} + {1'b0, remain_q};
  assign cfgBad  = (remain_q == '0) || ((addr_q & WordMask) != '0) ||
                   ((remain_q & WordMask) != '0) || (endAddr > AddrSpace);

  logic timeoutHit;

`ifdef OTP_CTRL_RD_SCHED_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wdog_q, wdog_d;

  assign timeoutHit = (wdog_q == WdW'(TimeoutCycles - 1));
  assign wdog_d     = (state_d != state_q) ? '0 :
                      ((state_q == StIssue) || (state_q == StWait)) ? wdog_q + 1'b1 : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unusedTimeout;

  assign timeoutHit    = 1'b0;
  assign unusedTimeout = |TimeoutCycles;
`endif

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    wordIdx_d = wordIdx_q;
    err_d     = err_q;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    rword_d   = rword_q;
    case (state_q)
      StIdle: begin
        if (pickValid) begin
          grant_d   = pickIdx;
          addr_d    = offArr[pickIdx];
          remain_d  = sizeArr[pickIdx];
          wordIdx_d = '0;
          rrPtr_d   = (pickIdx == IdxW'(NumPart - 1)) ? '0 : pickIdx + 1'b1;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        if (cfgBad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (otp_gnt_i) begin
          state_d = StWait;
        end else if (timeoutHit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        if (otp_rvalid_i) begin
          if (otp_err_i) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            rvalid_d  = OneHot0 << grant_q;
            rdata_d   = otp_rdata_i;
            rword_d   = wordIdx_q;
            addr_d    = addr_q + WordStep;
            remain_d  = remain_q - WordStep;
            wordIdx_d = wordIdx_q + 1'b1;
            state_d   = (remain_q == WordStep) ? StDone : StIssue;
          end
        end else if (timeoutHit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      remain_q  <= '0;
      wordIdx_q <= '0;
      err_q     <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      rword_q   <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      wordIdx_q <= wordIdx_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rword_q   <= rword_d;
    end
  end

  assign otp_req_o     = (state_q == StIssue);
  assign otp_addr_o    = otp_req_o ? addr_q : '0;
  assign busy_o        = (state_q != StIdle);
  assign part_ack_o    = (state_q == StDone) ? (OneHot0 << grant_q) : '0;
  assign part_err_o    = (state_q == StDone) && err_q;
  assign part_rvalid_o = rvalid_q;
  assign part_rdata_o  = rdata_q;
  assign part_rword_o  = rword_q;

endmodule

// File: tb/tb_otp_ctrl_part_rd_sched.sv
// Self-checking bench for otp_ctrl_part_rd_sched: randomized OTP responder plus a readout-level reference model.
// Timeout scenario is compiled in when OTP_CTRL_RD_SCHED_TIMEOUT_EN is defined.
module tb_otp_ctrl_part_rd_sched;

  localparam int NumPart = 8;
  localparam int AW      = 11;
  localparam int WB      = 8;
  localparam int DW      = WB * 8;
  localparam int Tmo     = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NumPart-1:0]     part_req_i;
  logic [NumPart*AW-1:0]  part_offset_i;
  logic [NumPart*AW-1:0]  part_size_i;
  logic [NumPart-1:0]     part_ack_o;
  logic                   part_err_o;
  logic [NumPart-1:0]     part_rvalid_o;
  logic [DW-1:0]          part_rdata_o;
  logic [AW-1:0]          part_rword_o;
  logic                   otp_req_o;
  logic [AW-1:0]          otp_addr_o;
  logic                   otp_gnt_i;
  logic                   otp_rvalid_i;
  logic [DW-1:0]          otp_rdata_i;
  logic                   otp_err_i;
  logic                   busy_o;

  otp_ctrl_part_rd_sched #(
    .NumPart(NumPart), .OtpByteAddrWidth(AW), .OtpWordBytes(WB), .TimeoutCycles(Tmo)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .part_req_i(part_req_i), .part_offset_i(part_offset_i), .part_size_i(part_size_i),
    .part_ack_o(part_ack_o), .part_err_o(part_err_o),
    .part_rvalid_o(part_rvalid_o), .part_rdata_o(part_rdata_o), .part_rword_o(part_rword_o),
    .otp_req_o(otp_req_o), .otp_addr_o(otp_addr_o), .otp_gnt_i(otp_gnt_i),
    .otp_rvalid_i(otp_rvalid_i), .otp_rdata_i(otp_rdata_i), .otp_err_i(otp_err_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [256];
  int cfgOff  [NumPart];
  int cfgSize [NumPart];
  int errAt  = -1;
  int holdAt = -1;
  int rrModel = 0;
  int assertCount = 0;
  int failCount   = 0;

  // OTP macro model: random grant/response latency, one command outstanding, spurious strobes when idle.
  int respCount;
  bit outstanding;
  logic [AW-1:0] respAddr;
  int gntWait, respDelay;

  initial begin
    otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_rdata_i = '0; otp_err_i = 1'b0;
    outstanding = 1'b0; respCount = 0; gntWait = 0; respDelay = 0; respAddr = '0;
    forever begin
      @(negedge clk_i);
      otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_err_i = 1'b0;
      if (rst_i) begin
        outstanding = 1'b0;
        respCount   = 0;
      end else begin
        if (!busy_o) respCount = 0;
        if (outstanding) begin
          if (respCount == holdAt) begin
            respDelay = 0;
          end else if (respDelay > 0) begin
            respDelay--;
          end else begin
            otp_rvalid_i = 1'b1;
            otp_rdata_i  = mem[respAddr[AW-1:3]];
            otp_err_i    = (respCount == errAt);
            outstanding  = 1'b0;
            respCount++;
          end
        end else begin
          if ($urandom_range(0, 3) == 0) begin
            otp_rvalid_i = 1'b1;
            otp_rdata_i  = {$urandom, $urandom};
            otp_err_i    = 1'($urandom_range(0, 1));
          end
          if (otp_req_o) begin
            if (gntWait > 0) begin
              gntWait--;
            end else begin
              otp_gnt_i   = 1'b1;
              respAddr    = otp_addr_o;
              outstanding = 1'b1;
              respDelay   = $urandom_range(0, 3);
              gntWait     = $urandom_range(0, 2);
            end
          end else if ($urandom_range(0, 7) == 0) begin
            otp_gnt_i = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input int off, input int sz, input bit req);
    cfgOff[k]  = off;
    cfgSize[k] = sz;
    part_offset_i[k*AW +: AW] = AW'(off);
    part_size_i[k*AW +: AW]   = AW'(sz);
    if (req) part_req_i[k] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Serve the readout the model predicts wins arbitration next; errAtIn selects a failing response.
  task automatic serveOne(input int errAtIn);
    int winner, off, sz, words, expStrobes, expIssued, issued, strobes, c;
    bit expErr, cfgErr, done;
    winner = -1;
    for (int i = 0; i < NumPart; i++) begin
      c = (rrModel + i) % NumPart;
      if (winner < 0 && part_req_i[c]) winner = c;
    end
    if (winner < 0) winner = 0;
    rrModel = (winner + 1) % NumPart;
    off = cfgOff[winner];
    sz  = cfgSize[winner];
    words  = sz / WB;
    cfgErr = (sz == 0) || (off % WB != 0) || (sz % WB != 0) || (off + sz > (1 << AW));
    if (cfgErr) begin
      expStrobes = 0; expIssued = 0; expErr = 1'b1;
    end else if (errAtIn >= 0 && errAtIn < words) begin
      expStrobes = errAtIn; expIssued = errAtIn + 1; expErr = 1'b1;
    end else begin
      expStrobes = words; expIssued = words; expErr = 1'b0;
    end
    errAt = errAtIn;
    issued = 0; strobes = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      tick();
      if (otp_req_o && otp_gnt_i) begin
        checkOutput("otp_addr", 64'(otp_addr_o), 64'(off + WB * issued));
        issued++;
      end
      if (part_rvalid_o != '0) begin
        checkOutput("rvalid_vec", 64'(part_rvalid_o), 64'(1) << winner);
        checkOutput("rdata", part_rdata_o, mem[(off / WB + strobes) % 256]);
        checkOutput("rword", 64'(part_rword_o), 64'(strobes));
        strobes++;
      end
      if (part_ack_o != '0) begin
        checkOutput("ack_vec", 64'(part_ack_o), 64'(1) << winner);
        checkOutput("ack_err", 64'(part_err_o), 64'(expErr));
        checkOutput("strobe_count", 64'(strobes), 64'(expStrobes));
        checkOutput("issue_count", 64'(issued), 64'(expIssued));
        part_req_i[winner] = 1'b0;
        done = 1'b1;
      end else if (part_err_o !== 1'b0) begin
        checkOutput("err_outside_done", 64'(part_err_o), 64'd0);
      end
    end
    checkOutput("ack_seen", 64'(done), 64'd1);
    errAt = -1;
  endtask

  initial begin
    int grants, mask, mode, nw, gntCycle, ackCycle;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < NumPart; k++) begin cfgOff[k] = 0; cfgSize[k] = 0; end
    rst_i = 1'b1; part_req_i = '0; part_offset_i = '0; part_size_i = '0;
    repeat (3) tick();
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_ack", 64'(part_ack_o), 64'd0);
    checkOutput("rst_err", 64'(part_err_o), 64'd0);
    checkOutput("rst_rvalid", 64'(part_rvalid_o), 64'd0);
    checkOutput("rst_rdata", part_rdata_o, 64'd0);
    checkOutput("rst_rword", 64'(part_rword_o), 64'd0);
    checkOutput("rst_otp_req", 64'(otp_req_o), 64'd0);
    checkOutput("rst_otp_addr", 64'(otp_addr_o), 64'd0);
    rst_i = 1'b0;
    repeat (2) tick();

    $display("[TB] partition 0 full readout");
    applyStimulus(0, 'h000, 64, 1'b1);
    serveOne(-1);
    repeat (2) tick();

    $display("[TB] partitions 1 and 3 contend");
    applyStimulus(1, 'h040, 800, 1'b1);
    applyStimulus(3, 'h680, 80, 1'b1);
    serveOne(-1);
    tick();
    checkOutput("idle_after_done", 64'(busy_o), 64'd0);
    tick();
    checkOutput("p3_granted_next", 64'(busy_o), 64'd1);
    serveOne(-1);
    repeat (2) tick();

    $display("[TB] illegal configurations");
    applyStimulus(2, 'h000, 0, 1'b1);
    serveOne(-1);
    repeat (2) tick();
    applyStimulus(2, 'h005, 64, 1'b1);
    serveOne(-1);
    repeat (2) tick();
    applyStimulus(6, 'h7C8, 64, 1'b1);
    serveOne(-1);
    repeat (2) tick();
    applyStimulus(6, 'h7C0, 64, 1'b1);
    serveOne(-1);
    repeat (2) tick();

    $display("[TB] uncorrectable error on third response");
    applyStimulus(4, 'h6D0, 40, 1'b1);
    serveOne(2);
    repeat (2) tick();
    applyStimulus(4, 'h100, 24, 1'b1);
    serveOne(-1);
    repeat (2) tick();

    $display("[TB] reset during word 5");
    holdAt = 5;
    applyStimulus(5, 'h200, 64, 1'b1);
    grants = 0;
    for (int cyc = 0; cyc < 500 && grants < 6; cyc++) begin
      tick();
      if (otp_req_o && otp_gnt_i) grants++;
    end
    checkOutput("word5_reached", 64'(grants), 64'd6);
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("mid_rst_rvalid", 64'(part_rvalid_o), 64'd0);
    checkOutput("mid_rst_rdata", part_rdata_o, 64'd0);
    checkOutput("mid_rst_otp_req", 64'(otp_req_o), 64'd0);
    part_req_i = '0;
    holdAt = -1;
    for (int cyc = 0; cyc < 2; cyc++) begin
      tick();
      checkOutput("mid_rst_no_ack", 64'(part_ack_o), 64'd0);
    end
    rst_i = 1'b0;
    rrModel = 0;
    repeat (2) tick();
    applyStimulus(2, 'h300, 32, 1'b1);
    applyStimulus(6, 'h380, 32, 1'b1);
    serveOne(-1);
    serveOne(-1);
    repeat (2) tick();

`ifdef OTP_CTRL_RD_SCHED_TIMEOUT_EN
    $display("[TB] response watchdog");
    holdAt = 0;
    applyStimulus(7, 'h400, 16, 1'b1);
    gntCycle = -1; ackCycle = -1;
    for (int cyc = 0; cyc < 200 && ackCycle < 0; cyc++) begin
      tick();
      if (otp_req_o && otp_gnt_i && gntCycle < 0) gntCycle = cyc;
      if (part_ack_o != '0) begin
        ackCycle = cyc;
        checkOutput("tmo_ack_vec", 64'(part_ack_o), 64'h80);
        checkOutput("tmo_ack_err", 64'(part_err_o), 64'd1);
        checkOutput("tmo_no_strobe", 64'(part_rvalid_o), 64'd0);
        part_req_i[7] = 1'b0;
      end
    end
    checkOutput("tmo_latency", 64'(ackCycle - gntCycle), 64'(Tmo + 1));
    rrModel = 0;
    holdAt = -1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (part_rvalid_o != '0) seen = 1'b1;
    end
    checkOutput("tmo_late_ignored", 64'(seen), 64'd0);
`endif

    $display("[TB] randomized readouts");
    for (int it = 0; it < 25; it++) begin
      mask = $urandom_range(1, 255);
      for (int k = 0; k < NumPart; k++) begin
        if (mask[k]) begin
          mode = $urandom_range(0, 9);
          nw   = $urandom_range(1, 8);
          case (mode)
            0:       applyStimulus(k, WB * $urandom_range(0, 200), 0, 1'b1);
            1:       applyStimulus(k, WB * $urandom_range(0, 200) + $urandom_range(1, 7), WB * nw, 1'b1);
            2:       applyStimulus(k, 2048 - WB, WB * (nw + 1), 1'b1);
            3:       applyStimulus(k, WB * $urandom_range(0, 200), WB * nw + $urandom_range(1, 7), 1'b1);
            default: applyStimulus(k, WB * $urandom_range(0, 256 - nw), WB * nw, 1'b1);
          endcase
        end
      end
      for (int n = 0; n < NumPart && part_req_i != '0; n++) begin
        serveOne(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1);
      end
      repeat ($urandom_range(2, 4)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
